// File: rtl/arythcrypt_pkg.sv
// Shared types and constants for the arythcrypt host framer slice.
package arythcrypt_pkg;

  // Host command carried on uio_in[2:1] alongside each strobe.
  typedef enum logic [1:0] {
    LOAD_KEY  = 2'b00,
    LOAD_DATA = 2'b01,
    START     = 2'b10,
    READ      = 2'b11
  } cmd_e;

  // Framer sequencing: waiting for operands, core busy, result unloading.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  // Bit positions inside the 4-bit status word {err, has_result, running, ready}.
  localparam int ST_READY = 0;
  localparam int ST_RUN   = 1;
  localparam int ST_RES   = 2;
  localparam int ST_ERR   = 3;

  // Operand/result width used by the tt_um_arythcrypto top level.
  localparam int DEFAULT_WORD_W = 16;

endpackage

// File: rtl/arythcrypt_strobe_sync.sv
// Two-flop synchroniser plus rising-edge detector for an asynchronous host
// strobe. Produces a registered one-cycle evt per sampled rising edge.
// The edge detector is held "armed high" until the synchroniser has refilled
// after reset, so a strobe held high through reset never looks like a rise.
module arythcrypt_strobe_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic evt
);

  logic       s1_q, s1_d;
  logic       s2_q, s2_d;
  logic       prev_q, prev_d;
  logic       evt_q, evt_d;
  logic [1:0] arm_q, arm_d;

  // Next-state: shift the synchroniser, track the previous level, flag rises.
  always_comb begin
    s1_d   = async_in;
    s2_d   = s1_q;
    arm_d  = {arm_q[0], 1'b1};
    prev_d = arm_q[1] ? s2_q : 1'b1;
    evt_d  = s2_q & ~prev_q;
  end

  // Register update with synchronous reset; prev resets high to suppress a false rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      prev_q <= 1'b1;
      arm_q  <= 2'b00;
      evt_q  <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      prev_q <= prev_d;
      arm_q  <= arm_d;
      evt_q  <= evt_d;
    end
  end

  assign evt = evt_q;

endmodule

// File: rtl/arythcrypt_host_framer.sv
// Host-side front end for the arythcrypt core: assembles byte-serial key and
// data operands, launches the core, captures its result and unloads it
// byte-serially, MSB byte first. WORD_W must be a multiple of 8 in 8..64.
//
// Core handshake: core_start is a one-cycle launch pulse issued only on the
// IDLE->RUN transition; the core answers with a one-cycle core_done, and
// core_result is valid only in that cycle. There is no backpressure in either
// direction; core_done is ignored unless the framer is in RUN.
module arythcrypt_host_framer
  import arythcrypt_pkg::*;
#(
  parameter int WORD_W = DEFAULT_WORD_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_byte,
  input  logic              in_strobe,
  input  logic [1:0]        in_cmd,
  output logic [WORD_W-1:0] core_key,
  output logic [WORD_W-1:0] core_data,
  output logic              core_start,
  input  logic              core_done,
  input  logic [WORD_W-1:0] core_result,
  output logic [7:0]        out_byte,
  output logic [3:0]        status
);

  localparam int BYTES = WORD_W / 8;
  localparam int CNT_W = $clog2(BYTES + 1);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e            state_q, state_d;
  logic [WORD_W-1:0] key_q, key_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic [WORD_W-1:0] res_q, res_d;
  logic [CNT_W-1:0]  key_cnt_q, key_cnt_d;
  logic [CNT_W-1:0]  data_cnt_q, data_cnt_d;
  logic [CNT_W-1:0]  res_cnt_q, res_cnt_d;
  logic              key_full_q, key_full_d;
  logic              data_full_q, data_full_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [7:0]        out_byte_q, out_byte_d;

  logic              byte_evt;
  cmd_e              cmd;
  logic [7:0]        rd_byte;

  arythcrypt_strobe_sync u_strobe_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (in_strobe),
    .evt      (byte_evt)
  );

  assign cmd = cmd_e'(in_cmd);

  // Select the result byte addressed by res_cnt, counting from the MSB byte.
  always_comb begin
    rd_byte = 8'h00;
    for (int b = 0; b < BYTES; b++) begin
      if (res_cnt_q == CNT_W'(BYTES - 1 - b)) rd_byte = res_q[b*8 +: 8];
    end
  end

  // Next-state and datapath: decode host commands, then handle core completion.
  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    data_d      = data_q;
    res_d       = res_q;
    key_cnt_d   = key_cnt_q;
    data_cnt_d  = data_cnt_q;
    res_cnt_d   = res_cnt_q;
    key_full_d  = key_full_q;
    data_full_d = data_full_q;
    err_d       = err_q;
    start_d     = 1'b0;
    out_byte_d  = out_byte_q;

    if (byte_evt) begin
      if (state_q == RUN) begin
        // Operands feed the running core, so every host byte is refused here.
        err_d = 1'b1;
      end else begin
        unique case (cmd)
          LOAD_KEY: begin
            if (key_full_q) begin
              err_d = 1'b1;
            end else begin
              key_d      = (key_q << 8) | WORD_W'(in_byte);
              key_cnt_d  = key_cnt_q + CNT_ONE;
              key_full_d = (key_cnt_q == CNT_LAST);
            end
          end
          LOAD_DATA: begin
            if (data_full_q) begin
              err_d = 1'b1;
            end else begin
              data_d      = (data_q << 8) | WORD_W'(in_byte);
              data_cnt_d  = data_cnt_q + CNT_ONE;
              data_full_d = (data_cnt_q == CNT_LAST);
            end
          end
          START: begin
            if ((state_q == IDLE) && key_full_q && data_full_q) begin
              start_d = 1'b1;
              state_d = RUN;
              err_d   = 1'b0;
            end else begin
              err_d = 1'b1;
            end
          end
          READ: begin
            if (state_q == DONE) begin
              out_byte_d = rd_byte;
              if (res_cnt_q == CNT_LAST) begin
                // Result fully unloaded: both operands must be loaded afresh.
                state_d     = IDLE;
                res_cnt_d   = '0;
                key_cnt_d   = '0;
                key_full_d  = 1'b0;
                data_cnt_d  = '0;
                data_full_d = 1'b0;
              end else begin
                res_cnt_d = res_cnt_q + CNT_ONE;
              end
            end else begin
              err_d = 1'b1;
            end
          end
        endcase
      end
    end

    if ((state_q == RUN) && core_done) begin
      state_d   = DONE;
      res_d     = core_result;
      res_cnt_d = '0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand, result, counter and flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      key_q       <= '0;
      data_q      <= '0;
      res_q       <= '0;
      key_cnt_q   <= '0;
      data_cnt_q  <= '0;
      res_cnt_q   <= '0;
      key_full_q  <= 1'b0;
      data_full_q <= 1'b0;
      err_q       <= 1'b0;
      start_q     <= 1'b0;
      out_byte_q  <= 8'h00;
    end else begin
      key_q       <= key_d;
      data_q      <= data_d;
      res_q       <= res_d;
      key_cnt_q   <= key_cnt_d;
      data_cnt_q  <= data_cnt_d;
      res_cnt_q   <= res_cnt_d;
      key_full_q  <= key_full_d;
      data_full_q <= data_full_d;
      err_q       <= err_d;
      start_q     <= start_d;
      out_byte_q  <= out_byte_d;
    end
  end

  // Status word derived directly from the registered state.
  always_comb begin
    status           = 4'b0000;
    status[ST_READY] = key_full_q & data_full_q & (state_q == IDLE);
    status[ST_RUN]   = (state_q == RUN);
    status[ST_RES]   = (state_q == DONE);
    status[ST_ERR]   = err_q;
  end

  assign core_key   = key_q;
  assign core_data  = data_q;
  assign core_start = start_q;
  assign out_byte   = out_byte_q;

endmodule

// File: tb/tb_arythcrypt_host_framer.sv
// Directed bench for arythcrypt_host_framer at WORD_W=16 with a simple
// fixed-latency core model and an expected-byte queue for result unloads.
module tb_arythcrypt_host_framer;
  import arythcrypt_pkg::*;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [7:0]   in_byte;
  logic         in_strobe;
  logic [1:0]   in_cmd;
  logic [W-1:0] core_key;
  logic [W-1:0] core_data;
  logic         core_start;
  logic         core_done;
  logic [W-1:0] core_result;
  logic [7:0]   out_byte;
  logic [3:0]   status;

  int           n_vec;
  int           n_err;
  int           start_cnt;
  int           core_lat;
  logic [W-1:0] core_res_val;
  logic [7:0]   exp_q[$];

  arythcrypt_host_framer #(.WORD_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_byte     (in_byte),
    .in_strobe   (in_strobe),
    .in_cmd      (in_cmd),
    .core_key    (core_key),
    .core_data   (core_data),
    .core_start  (core_start),
    .core_done   (core_done),
    .core_result (core_result),
    .out_byte    (out_byte),
    .status      (status)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // ---------------- core model ----------------
  initial begin
    core_done   = 1'b0;
    core_result = '0;
    forever begin
      @(negedge clk);
      if (core_start) begin
        repeat (core_lat) @(negedge clk);
        core_done   = 1'b1;
        core_result = core_res_val;
        @(negedge clk);
        core_done   = 1'b0;
        core_result = '0;
      end
    end
  end

  // Counts every cycle in which core_start is high.
  initial begin
    start_cnt = 0;
    forever begin
      @(negedge clk);
      if (core_start) start_cnt++;
    end
  end

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic send(input logic [1:0] cmd, input logic [7:0] b);
    @(negedge clk);
    in_cmd    = cmd;
    in_byte   = b;
    in_strobe = 1'b1;
    repeat (4) @(negedge clk);
    in_strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_result(input logic [W-1:0] r);
    core_res_val = r;
    exp_q.push_back(r[15:8]);
    exp_q.push_back(r[7:0]);
  endtask

  task automatic read_check(input string tag);
    logic [7:0] e;
    send(READ, 8'h00);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check_eq(tag, out_byte, e);
  endtask

  task automatic wait_result(input string tag, input int budget);
    int k;
    k = 0;
    while (!status[ST_RES] && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_eq(tag, status, 4'b0100 | (status & 4'b1000));
  endtask

  // Bounds the whole run in case a wait never completes.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int s0;
    n_vec        = 0;
    n_err        = 0;
    core_lat     = 5;
    core_res_val = '0;
    in_byte      = 8'h00;
    in_cmd       = 2'b00;
    in_strobe    = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    apply_reset(3);

    // Reset state
    check_eq("rst_key", core_key, 16'h0000);
    check_eq("rst_data", core_data, 16'h0000);
    check_eq("rst_start", core_start, 1'b0);
    check_eq("rst_out", out_byte, 8'h00);
    check_eq("rst_status", status, 4'b0000);

    // Operand load
    send(LOAD_KEY, 8'hAB);
    check_eq("key_partial_status", status, 4'b0000);
    send(LOAD_KEY, 8'hCD);
    send(LOAD_DATA, 8'h12);
    send(LOAD_DATA, 8'h34);
    check_eq("load_key", core_key, 16'hABCD);
    check_eq("load_data", core_data, 16'h1234);
    check_eq("load_status", status, 4'b0001);
    check_eq("load_no_start", start_cnt, 0);

    // Launch, result, unload
    expect_result(16'hBEEF);
    s0 = start_cnt;
    send(START, 8'h00);
    check_eq("start_pulses", start_cnt - s0, 1);
    check_eq("run_status", status, 4'b0010);
    wait_result("done_status", 50);
    read_check("read_hi");
    check_eq("read_hi_status", status, 4'b0100);
    read_check("read_lo");
    check_eq("after_read_status", status, 4'b0000);
    repeat (5) @(negedge clk);
    check_eq("out_hold", out_byte, 8'hEF);

    // START with only the key loaded, then a valid START clears err
    send(LOAD_KEY, 8'hAB);
    send(LOAD_KEY, 8'hCD);
    s0 = start_cnt;
    send(START, 8'h00);
    check_eq("bad_start_pulses", start_cnt - s0, 0);
    check_eq("bad_start_status", status, 4'b1000);
    send(LOAD_DATA, 8'h12);
    send(LOAD_DATA, 8'h34);
    check_eq("err_sticky_ready", status, 4'b1001);
    expect_result(16'h5A3C);
    s0 = start_cnt;
    send(START, 8'h00);
    check_eq("good_start_pulses", start_cnt - s0, 1);
    check_eq("err_cleared", status, 4'b0010);
    wait_result("done2_status", 50);
    read_check("read2_hi");
    read_check("read2_lo");

    // Third key byte overflows
    send(LOAD_KEY, 8'hAB);
    send(LOAD_KEY, 8'hCD);
    send(LOAD_KEY, 8'h77);
    check_eq("ovf_key", core_key, 16'hABCD);
    check_eq("ovf_status", status, 4'b1000);
    send(LOAD_DATA, 8'h56);
    send(LOAD_DATA, 8'h78);
    check_eq("ovf_data", core_data, 16'h5678);
    check_eq("ovf_ready", status, 4'b1001);

    // LOAD_DATA during RUN
    core_lat = 20;
    expect_result(16'hC3A5);
    send(START, 8'h00);
    check_eq("run2_status", status, 4'b0010);
    send(LOAD_DATA, 8'h99);
    check_eq("run_load_data", core_data, 16'h5678);
    check_eq("run_load_status", status, 4'b1010);
    wait_result("done3_status", 50);
    read_check("read3_hi");
    read_check("read3_lo");
    check_eq("read3_status", status, 4'b1000);
    send(READ, 8'h00);
    check_eq("idle_read_out", out_byte, 8'hA5);
    check_eq("idle_read_status", status, 4'b1000);

    // Reset during RUN; the late core_done must be ignored
    core_lat = 10;
    core_res_val = 16'hDEAD;
    send(LOAD_KEY, 8'h01);
    send(LOAD_KEY, 8'h02);
    send(LOAD_DATA, 8'h03);
    send(LOAD_DATA, 8'h04);
    send(START, 8'h00);
    check_eq("run4_status", status, 4'b0010);
    apply_reset(2);
    repeat (10) @(negedge clk);
    check_eq("midrun_rst_status", status, 4'b0000);
    check_eq("midrun_rst_key", core_key, 16'h0000);
    check_eq("midrun_rst_out", out_byte, 8'h00);

    // Strobe held high across reset
    core_lat  = 5;
    rst       = 1'b1;
    in_cmd    = LOAD_KEY;
    in_byte   = 8'hFF;
    in_strobe = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check_eq("held_key", core_key, 16'h0000);
    check_eq("held_status", status, 4'b0000);
    in_strobe = 1'b0;
    repeat (4) @(negedge clk);
    send(LOAD_KEY, 8'h12);
    send(LOAD_KEY, 8'h34);
    check_eq("held_reload_key", core_key, 16'h1234);
    check_eq("held_reload_status", status, 4'b0000);

    // Short strobe pulse spanning one clock edge yields a single byte
    @(negedge clk);
    in_cmd    = LOAD_DATA;
    in_byte   = 8'h56;
    in_strobe = 1'b1;
    #6;
    in_strobe = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("glitch_data", core_data, 16'h0056);
    send(LOAD_DATA, 8'h78);
    check_eq("glitch_data2", core_data, 16'h5678);
    check_eq("glitch_status", status, 4'b0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
